// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths and the writeback
// entry carried from the LSU queue to the register file port.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int NB_REGS = 5;

    typedef struct packed {
        logic [NB_REGS-1:0] adr;
        logic [XLEN-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; the head is
// registered, so a pushed entry is visible one cycle later.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  wb_entry_t     din,
    input  logic          pop,
    output wb_entry_t     dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage array; contents need no reset since count gates use
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; reset discards everything queued
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU first, LSU results queued
// and drained in idle slots, with a starvation-forced ALU stall.
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int NB_REGS    = riscv_pkg::NB_REGS,
    parameter int LSU_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alu_valid_i,
    input  logic [NB_REGS-1:0] alu_adr_i,
    input  logic [XLEN-1:0]    alu_data_i,
    output logic               alu_stall_o,
    input  logic               lsu_valid_i,
    output logic               lsu_ready_o,
    input  logic [NB_REGS-1:0] lsu_adr_i,
    input  logic [XLEN-1:0]    lsu_data_i,
    output logic               write_valid_o,
    output logic [NB_REGS-1:0] write_adr_o,
    output logic [XLEN-1:0]    write_data_o,
    input  logic [NB_REGS-1:0] rs1_adr_i,
    input  logic [NB_REGS-1:0] rs2_adr_i,
    output logic               rs1_byp_valid_o,
    output logic [XLEN-1:0]    rs1_byp_data_o,
    output logic               rs2_byp_valid_o,
    output logic [XLEN-1:0]    rs2_byp_data_o
);

    localparam int AW = $clog2(LSU_DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    wb_entry_t       head;
    wb_entry_t       lsu_entry;
    wb_entry_t       sel;
    logic            full;
    logic            empty;
    logic [AW:0]     fifo_cnt;
    logic [CW-1:0]   starve_cnt;
    logic            push;
    logic            pop;
    logic            alu_take;
    logic            consumed;

    assign lsu_entry   = '{adr: lsu_adr_i, data: lsu_data_i};
    assign lsu_ready_o = ~full & ~reset;
    assign push        = lsu_valid_i & lsu_ready_o;

    // Stall only makes sense with a head waiting to be written
    assign alu_stall_o = (starve_cnt == STARVE_LIM)
                       & (fifo_cnt != '0) & ~reset;

    assign pop      = ~empty & (alu_stall_o | ~alu_valid_i);
    assign alu_take = alu_valid_i & ~alu_stall_o;
    assign consumed = pop | alu_take;
    assign sel      = pop ? head
                          : '{adr: alu_adr_i, data: alu_data_i};

    wb_fifo #(
        .DEPTH (LSU_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (lsu_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

    // Count arbitrations the queued head has lost to the ALU
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (pop | empty) begin
            starve_cnt <= '0;
        end else if (alu_take) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // Write-stage register; x0 results are consumed but not written
    always_ff @(posedge clk) begin
        if (reset) begin
            write_valid_o <= 1'b0;
            write_adr_o   <= '0;
            write_data_o  <= '0;
        end else begin
            write_valid_o <= consumed & (sel.adr != '0);
            if (consumed) begin
                write_adr_o  <= sel.adr;
                write_data_o <= sel.data;
            end
        end
    end

    // Forward the in-flight write to decode until the RF absorbs it
    always_comb begin
        rs1_byp_valid_o = 1'b0;
        rs1_byp_data_o  = '0;
        rs2_byp_valid_o = 1'b0;
        rs2_byp_data_o  = '0;
        if (write_valid_o && write_adr_o == rs1_adr_i
                && rs1_adr_i != '0) begin
            rs1_byp_valid_o = 1'b1;
            rs1_byp_data_o  = write_data_o;
        end
        if (write_valid_o && write_adr_o == rs2_adr_i
                && rs2_adr_i != '0) begin
            rs2_byp_valid_o = 1'b1;
            rs2_byp_data_o  = write_data_o;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    typedef struct {
        logic [4:0]  adr;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_adr;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_adr;
    logic [31:0] lsu_data;
    logic        wr_valid;
    logic [4:0]  wr_adr;
    logic [31:0] wr_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        b1_valid;
    logic [31:0] b1_data;
    logic        b2_valid;
    logic [31:0] b2_data;

    int errors = 0;
    int checks = 0;

    ent_t        mq[$];
    int          m_lost;
    bit          m_wv;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          m_rst;
    bit          m_pushed;
    bit          m_stall;

    always #5 clk = ~clk;

    wb_arbiter #(
        .LSU_DEPTH  (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid_i     (alu_valid),
        .alu_adr_i       (alu_adr),
        .alu_data_i      (alu_data),
        .alu_stall_o     (alu_stall),
        .lsu_valid_i     (lsu_valid),
        .lsu_ready_o     (lsu_ready),
        .lsu_adr_i       (lsu_adr),
        .lsu_data_i      (lsu_data),
        .write_valid_o   (wr_valid),
        .write_adr_o     (wr_adr),
        .write_data_o    (wr_data),
        .rs1_adr_i       (rs1),
        .rs2_adr_i       (rs2),
        .rs1_byp_valid_o (b1_valid),
        .rs1_byp_data_o  (b1_data),
        .rs2_byp_valid_o (b2_valid),
        .rs2_byp_data_o  (b2_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: check combinational outputs against the
    // model, advance the model, then check the registered write port.
    task automatic cycle();
        bit   exp_ready;
        bit   hit1;
        bit   hit2;
        bit   was_empty;
        bit   take;
        ent_t e;
        #1;
        exp_ready = !reset && mq.size() < DEPTH;
        m_stall   = !reset && m_lost == SMAX;
        hit1 = m_wv && m_wa == rs1 && rs1 != 0;
        hit2 = m_wv && m_wa == rs2 && rs2 != 0;
        chk("alu_stall", alu_stall, m_stall);
        chk("lsu_ready", lsu_ready, exp_ready);
        chk("rs1_hit", b1_valid, hit1);
        chk("rs1_data", b1_data, hit1 ? m_wd : 32'd0);
        chk("rs2_hit", b2_valid, hit2);
        chk("rs2_data", b2_data, hit2 ? m_wd : 32'd0);
        m_pushed = 1'b0;
        if (reset) begin
            mq.delete();
            m_lost = 0;
            m_wv   = 1'b0;
            m_wa   = '0;
            m_wd   = '0;
            m_rst  = 1'b1;
        end else begin
            m_rst     = 1'b0;
            was_empty = (mq.size() == 0);
            take      = 1'b0;
            e         = '{adr: '0, data: '0};
            if (!was_empty && (m_stall || !alu_valid)) begin
                e = mq.pop_front();
                take = 1'b1;
                m_lost = 0;
            end else if (alu_valid) begin
                e = '{adr: alu_adr, data: alu_data};
                take = 1'b1;
                m_lost = was_empty ? 0 : m_lost + 1;
            end else begin
                m_lost = 0;
            end
            if (lsu_valid && exp_ready) begin
                mq.push_back('{adr: lsu_adr, data: lsu_data});
                m_pushed = 1'b1;
            end
            m_wv = take && e.adr != 0;
            if (m_wv) begin
                m_wa = e.adr;
                m_wd = e.data;
            end
        end
        @(posedge clk);
        #1;
        chk("write_valid", wr_valid, m_wv);
        if (m_wv || m_rst) begin
            chk("write_adr", wr_adr, m_wa);
            chk("write_data", wr_data, m_wd);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_adr   = '0;
        alu_data  = '0;
        lsu_valid = 1'b0;
        lsu_adr   = '0;
        lsu_data  = '0;
        rs1       = '0;
        rs2       = '0;
    endtask

    initial begin
        int guard;
        idle_inputs();
        reset  = 1'b1;
        m_lost = 0;
        m_wv   = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
        m_rst  = 1'b1;
        m_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;
        cycle();

        // single ALU write with rs1 bypass on the following cycle
        alu_valid = 1'b1;
        alu_adr   = 5'd5;
        alu_data  = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        rs1 = 5'd5;
        cycle();

        // x0 destination is consumed silently
        alu_valid = 1'b1;
        alu_adr   = 5'd0;
        alu_data  = 32'h1234;
        rs2       = 5'd0;
        cycle();
        idle_inputs();
        cycle();

        // LSU queued, then ALU takes the slot, LSU follows
        lsu_valid = 1'b1;
        lsu_adr   = 5'd7;
        lsu_data  = 32'hA;
        cycle();
        idle_inputs();
        alu_valid = 1'b1;
        alu_adr   = 5'd3;
        alu_data  = 32'h33;
        rs1       = 5'd7;
        cycle();
        idle_inputs();
        rs1 = 5'd3;
        rs2 = 5'd7;
        cycle();
        cycle();

        // starvation: one queued entry against continuous ALU traffic
        lsu_valid = 1'b1;
        lsu_adr   = 5'd9;
        lsu_data  = 32'h9999;
        alu_valid = 1'b1;
        alu_adr   = 5'd4;
        alu_data  = 32'h4444;
        cycle();
        lsu_valid = 1'b0;
        repeat (8) cycle();
        idle_inputs();
        cycle();

        // fill the FIFO under ALU pressure, third push waits for a pop
        alu_valid = 1'b1;
        alu_adr   = 5'd2;
        alu_data  = 32'h2222;
        lsu_valid = 1'b1;
        lsu_adr   = 5'd10;
        lsu_data  = 32'h100;
        cycle();
        lsu_adr   = 5'd11;
        lsu_data  = 32'h101;
        cycle();
        lsu_adr   = 5'd12;
        lsu_data  = 32'h102;
        guard = 0;
        do begin
            cycle();
            guard++;
        end while (!m_pushed && guard < 20);
        chk("third_push_bound", guard < 20, 1'b1);
        idle_inputs();
        repeat (4) cycle();

        // reset with two queued entries discards them
        alu_valid = 1'b1;
        alu_adr   = 5'd1;
        alu_data  = 32'h11;
        lsu_valid = 1'b1;
        lsu_adr   = 5'd20;
        lsu_data  = 32'h200;
        cycle();
        lsu_adr   = 5'd21;
        lsu_data  = 32'h201;
        cycle();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (4) cycle();

        // random traffic; stalled ALU results are held upstream
        for (int i = 0; i < 600; i++) begin
            if (!m_stall || !alu_valid) begin
                alu_valid = ($urandom_range(0, 9) < 7);
                alu_adr   = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            lsu_valid = ($urandom_range(0, 9) < 4);
            lsu_adr   = 5'($urandom_range(0, 7));
            lsu_data  = $urandom;
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 7));
            reset     = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        repeat (6) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
